// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter for the memory controller port
//
// Shares the single memory-controller port between requester 0 (evaluator/CPU)
// and requester 1 (allocator/GC). Traffic is held off until the controller
// reports boot_done. After that, one access is granted per valid/ready handshake,
// and the arbiter alternates fairly between the requesters. A read takes one
// extra cycle: the controller returns read data one cycle after the address, and
// the arbiter routes that data back to the requester that issued the read.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   boot_done         controller boot complete; dropping it after boot is fatal
//   memory_error      controller error flag; fatal in any state
//   mem_write_enable  controller write strobe
//   mem_addr          controller word address
//   mem_write_data    controller write data
//   mem_read_data     controller read data, valid one cycle after mem_addr
//   req_valid[i]      requester i has a request
//   req_ready[i]      requester i is accepted this cycle (zero-latency)
//   req_we[i]         requester i request is a write (1) or a read (0)
//   req_addr          requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata         requester i write data at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid[i]      one-cycle read-response pulse to requester i
//   rsp_rdata         read data, qualified by rsp_valid
//   arb_error         sticky error indication, cleared only by rst_n

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    boot_done,
  input  logic                    memory_error,
  output logic                    mem_write_enable,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  input  logic [DATA_WIDTH-1:0]   mem_read_data,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    arb_error
);

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    IDLE      = 2'd1,
    READ_WAIT = 2'd2,
    ERROR     = 2'd3
  } state_t;

  state_t                  state, state_next;
  logic                    prio, prio_next;
  logic                    owner, owner_next;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_q_next;

  // Per-requester views of the packed request buses.
  logic [ADDR_WIDTH-1:0]   addr_0, addr_1;
  logic [DATA_WIDTH-1:0]   wdata_0, wdata_1;

  assign addr_0  = req_addr[0 +: ADDR_WIDTH];
  assign addr_1  = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
  assign wdata_0 = req_wdata[0 +: DATA_WIDTH];
  assign wdata_1 = req_wdata[DATA_WIDTH +: DATA_WIDTH];

  // Winner selection: a lone requester wins outright, and a conflict goes to
  // whoever prio currently favours.
  logic                    any_valid;
  logic                    winner;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic [DATA_WIDTH-1:0]   win_wdata;
  logic                    win_we;

  assign any_valid = |req_valid;
  assign winner    = (req_valid == 2'b11) ? prio : req_valid[1];
  assign win_addr  = winner ? addr_1  : addr_0;
  assign win_wdata = winner ? wdata_1 : wdata_0;
  assign win_we    = winner ? req_we[1] : req_we[0];

  // Fatal conditions seen this cycle. Losing boot_done only matters once the
  // controller has booted, so BOOT itself ignores it. When err_now is set, the
  // cycle issues no grant, no write and no response, which keeps a half-finished
  // read from being reported as good.
  logic err_now;
  assign err_now = memory_error |
                   (~boot_done & ((state == IDLE) | (state == READ_WAIT)));

  assign rsp_rdata = mem_read_data;
  assign arb_error = (state == ERROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BOOT;
      prio   <= 1'b0;
      owner  <= 1'b0;
      addr_q <= '0;
    end else begin
      state  <= state_next;
      prio   <= prio_next;
      owner  <= owner_next;
      addr_q <= addr_q_next;
    end
  end

  always_comb begin
    state_next       = state;
    prio_next        = prio;
    owner_next       = owner;
    addr_q_next      = addr_q;
    req_ready        = 2'b00;
    rsp_valid        = 2'b00;
    mem_write_enable = 1'b0;
    mem_addr         = '0;
    mem_write_data   = '0;

    if (err_now) begin
      state_next = ERROR;
    end else begin
      case (state)
        BOOT: begin
          if (boot_done) begin
            state_next = IDLE;
          end
        end

        IDLE: begin
          if (any_valid) begin
            req_ready        = winner ? 2'b10 : 2'b01;
            mem_addr         = win_addr;
            mem_write_data   = win_wdata;
            mem_write_enable = win_we;
            prio_next        = ~winner;
            // A write finishes at this edge, so IDLE can accept another one
            // next cycle. A read must wait for the controller's data.
            if (!win_we) begin
              owner_next  = winner;
              addr_q_next = win_addr;
              state_next  = READ_WAIT;
            end
          end
        end

        READ_WAIT: begin
          // Hold the address steady while the controller returns the data.
          mem_addr   = addr_q;
          rsp_valid  = owner ? 2'b10 : 2'b01;
          state_next = IDLE;
        end

        ERROR: begin
          state_next = ERROR;
        end

        default: begin
          state_next = ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        boot_done;
  logic        memory_error;
  logic        mem_write_enable;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        arb_error;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .boot_done(boot_done), .memory_error(memory_error),
    .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .arb_error(arb_error)
  );

  always #5 clk = ~clk;

  // Controller model: registered read, one-cycle latency. Unwritten words read
  // back as a fixed address pattern.
  logic [31:0]  ctrl_mem [256];
  logic [255:0] written = '0;
  always @(posedge clk) begin
    if (mem_write_enable) begin
      ctrl_mem[mem_addr[7:0]] <= mem_write_data;
      written[mem_addr[7:0]]  <= 1'b1;
    end
    mem_read_data <= written[mem_addr[7:0]] ? ctrl_mem[mem_addr[7:0]]
                                            : (32'h5A00_0000 | 32'(mem_addr[7:0]));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic reset_boot();
    rst_n = 1'b0; boot_done = 1'b0; memory_error = 1'b0; req_valid = 2'b00;
    tick(); tick();
    rst_n = 1'b1; boot_done = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [1:0] valid;
    logic [1:0] exp_ready;
  } vec_t;
  vec_t tbl[8];

  // Random-phase reference model state.
  logic [31:0] shadow [256];
  logic        m_prio, m_rd_pend, m_rd_owner;
  logic [15:0] m_rd_addr;
  logic [1:0]  rv, rwe, hs;
  logic [15:0] ra [2];
  logic [31:0] rd [2];

  initial begin
    tbl[0] = '{2'b11, 2'b01};
    tbl[1] = '{2'b11, 2'b10};
    tbl[2] = '{2'b10, 2'b10};
    tbl[3] = '{2'b10, 2'b10};
    tbl[4] = '{2'b11, 2'b01};
    tbl[5] = '{2'b01, 2'b01};
    tbl[6] = '{2'b00, 2'b00};
    tbl[7] = '{2'b11, 2'b10};

    // Reset held, then BOOT with requests waiting.
    rst_n = 1'b0; boot_done = 1'b0; memory_error = 1'b0;
    req_valid = 2'b11; req_we = 2'b11;
    req_addr = {16'h0055, 16'h0044}; req_wdata = {32'h1111_1111, 32'h2222_2222};
    tick(); tick(); tick();
    smp();
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_we", mem_write_enable, 1'b0);
    chk("rst_addr", mem_addr, 16'h0);
    chk("rst_wdata", mem_write_data, 32'h0);
    chk("rst_rsp", rsp_valid, 2'b00);
    chk("rst_err", arb_error, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      smp();
      chk("boot_ready", req_ready, 2'b00);
      chk("boot_we", mem_write_enable, 1'b0);
      tick();
    end
    boot_done = 1'b1;
    smp();
    chk("boot_edge_ready", req_ready, 2'b00);
    tick();
    smp();
    chk("first_grant", req_ready, 2'b01);
    chk("first_grant_addr", mem_addr, 16'h0044);
    tick();
    req_valid = 2'b00;

    // Table: single-cycle writes, round-robin from a fresh prio=0.
    reset_boot();
    for (int i = 0; i < 8; i++) begin
      req_valid = tbl[i].valid; req_we = 2'b11;
      req_addr  = {16'h0B00 | 16'(i), 16'h0A00 | 16'(i)};
      req_wdata = {32'hB000_0000 | 32'(i), 32'hA000_0000 | 32'(i)};
      smp();
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_we", i), mem_write_enable, tbl[i].exp_ready != 2'b00);
      chk($sformatf("tbl%0d_addr", i), mem_addr,
          tbl[i].exp_ready == 2'b01 ? (16'h0A00 | 16'(i)) :
          tbl[i].exp_ready == 2'b10 ? (16'h0B00 | 16'(i)) : 16'h0);
      chk($sformatf("tbl%0d_wdata", i), mem_write_data,
          tbl[i].exp_ready == 2'b01 ? (32'hA000_0000 | 32'(i)) :
          tbl[i].exp_ready == 2'b10 ? (32'hB000_0000 | 32'(i)) : 32'h0);
      tick();
    end

    // Write then read back from requester 0.
    req_valid = 2'b01; req_we = 2'b01;
    req_addr = {16'h0, 16'h0010}; req_wdata = {32'h0, 32'hDEAD_BEEF};
    smp();
    chk("wr_ready", req_ready, 2'b01);
    chk("wr_we", mem_write_enable, 1'b1);
    tick();
    req_we = 2'b00;
    smp();
    chk("rd_ready", req_ready, 2'b01);
    chk("rd_we", mem_write_enable, 1'b0);
    tick();
    req_valid = 2'b00;
    smp();
    chk("rd_rsp", rsp_valid, 2'b01);
    chk("rd_data", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_hold_addr", mem_addr, 16'h0010);
    chk("rd_wait_ready", req_ready, 2'b00);
    tick();

    // Continuous writes from both; prio now favours requester 1.
    req_valid = 2'b11; req_we = 2'b11;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk($sformatf("alt%0d", i), req_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    req_valid = 2'b00;

    // Reads from both after a fresh reset.
    reset_boot();
    req_valid = 2'b11; req_we = 2'b00; req_addr = {16'h0030, 16'h0020};
    smp();
    chk("rr_g0", req_ready, 2'b01);
    chk("rr_a0", mem_addr, 16'h0020);
    tick();
    req_valid = 2'b10;
    smp();
    chk("rr_rsp0", rsp_valid, 2'b01);
    chk("rr_d0", rsp_rdata, 32'h5A00_0020);
    chk("rr_h0", mem_addr, 16'h0020);
    chk("rr_w0", req_ready, 2'b00);
    tick();
    smp();
    chk("rr_g1", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    smp();
    chk("rr_rsp1", rsp_valid, 2'b10);
    chk("rr_d1", rsp_rdata, 32'h5A00_0030);
    chk("rr_h1", mem_addr, 16'h0030);
    tick();

    // memory_error during READ_WAIT.
    reset_boot();
    req_valid = 2'b01; req_we = 2'b00; req_addr = {16'h0, 16'h0021};
    smp();
    chk("er_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00; memory_error = 1'b1;
    smp();
    chk("er_no_rsp", rsp_valid, 2'b00);
    tick();
    memory_error = 1'b0; req_valid = 2'b11; req_we = 2'b11;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("er_sticky", arb_error, 1'b1);
      chk("er_ready", req_ready, 2'b00);
      chk("er_we", mem_write_enable, 1'b0);
      tick();
    end

    // Asynchronous reset in the middle of READ_WAIT.
    reset_boot();
    smp();
    chk("clr_err", arb_error, 1'b0);
    tick();
    req_valid = 2'b10; req_we = 2'b00; req_addr = {16'h0031, 16'h0};
    smp();
    chk("ar_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    #2;
    chk("ar_pre_rsp", rsp_valid, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("ar_rsp", rsp_valid, 2'b00);
    chk("ar_addr", mem_addr, 16'h0);
    chk("ar_ready", req_ready, 2'b00);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    req_valid = 2'b11; req_we = 2'b11;
    smp();
    chk("ar_prio", req_ready, 2'b01);
    tick();

    // Randomized traffic against a transaction-level model.
    reset_boot();
    for (int i = 0; i < 256; i++) shadow[i] = 32'h5A00_0000 | 32'(i);
    for (int i = 0; i < 256; i++) if (written[i]) shadow[i] = ctrl_mem[i];
    m_prio = 1'b0; m_rd_pend = 1'b0; m_rd_owner = 1'b0; m_rd_addr = '0;
    rv = 2'b00; rwe = 2'b00; ra[0] = '0; ra[1] = '0; rd[0] = '0; rd[1] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [1:0] exp_ready;
      logic       w;
      hs = 2'b00;
      for (int r = 0; r < 2; r++) begin
        if (!rv[r] && $urandom_range(0, 3) != 0) begin
          rv[r]  = 1'b1;
          rwe[r] = 1'($urandom_range(0, 1));
          ra[r]  = 16'h0040 + 16'($urandom_range(0, 15));
          rd[r]  = $urandom;
        end
      end
      req_valid = rv; req_we = rwe;
      req_addr = {ra[1], ra[0]}; req_wdata = {rd[1], rd[0]};
      smp();
      if (m_rd_pend) begin
        chk("rnd_wait_ready", req_ready, 2'b00);
        chk("rnd_rsp", rsp_valid, m_rd_owner ? 2'b10 : 2'b01);
        chk("rnd_rdata", rsp_rdata, shadow[m_rd_addr[7:0]]);
        chk("rnd_hold", mem_addr, m_rd_addr);
        m_rd_pend = 1'b0;
      end else begin
        chk("rnd_no_rsp", rsp_valid, 2'b00);
        if (rv == 2'b00) begin
          chk("rnd_idle_ready", req_ready, 2'b00);
          chk("rnd_idle_we", mem_write_enable, 1'b0);
        end else begin
          w = (rv == 2'b11) ? m_prio : rv[1];
          exp_ready = 2'b01 << w;
          chk("rnd_ready", req_ready, exp_ready);
          chk("rnd_addr", mem_addr, ra[w]);
          chk("rnd_we", mem_write_enable, rwe[w]);
          if (rwe[w]) begin
            chk("rnd_wdata", mem_write_data, rd[w]);
            shadow[ra[w][7:0]] = rd[w];
          end else begin
            m_rd_pend = 1'b1; m_rd_owner = w; m_rd_addr = ra[w];
          end
          m_prio = ~w;
          hs = exp_ready;
        end
      end
      tick();
      rv = rv & ~hs;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory-controller port between two requesters: requester 0 is the evaluator/CPU and requester 1 is the allocator/GC.
- Sits directly upstream of the memory controller's write_enable/addr/write_data/read_data port.
- Holds off all traffic until boot_done, then grants one access per handshake with round-robin fairness.
- Sequences the one-cycle read latency and routes read data back to the owning requester.

Parameters:
ADDR_WIDTH, 16, memory word-address width
DATA_WIDTH, 32, memory word width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
boot_done  in  1  memory controller boot complete
memory_error  in  1  memory controller error flag
mem_write_enable  out  1  to controller write_enable
mem_addr  out  ADDR_WIDTH  to controller addr
mem_write_data  out  DATA_WIDTH  to controller write_data
mem_read_data  in  DATA_WIDTH  from controller read_data (valid one cycle after addr presented)
req_valid  in  2  per-requester request valid, bit i = requester i
req_ready  out  2  per-requester accept; handshake = valid&ready same cycle
req_we  in  2  per-requester 1=write, 0=read
req_addr  in  2*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  2*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
rsp_valid  out  2  one-cycle read-response pulse to requester i
rsp_rdata  out  DATA_WIDTH  read data, qualified by rsp_valid
arb_error  out  1  sticky error indication

Behaviour:
- Registered state: state (BOOT, IDLE, READ_WAIT, ERROR), prio (1 bit), owner (1 bit), addr_q (ADDR_WIDTH). All other outputs are combinational from these registers and the inputs.
- rst_n low (asynchronous): state=BOOT, prio=0, owner=0, addr_q=0.
- While in reset: req_ready=0, rsp_valid=0, mem_write_enable=0, mem_addr=0, mem_write_data=0, arb_error=0.
- Defaults in every state: req_ready=0, rsp_valid=0, mem_write_enable=0, mem_addr=0, mem_write_data=0, rsp_rdata=mem_read_data.
- BOOT: no grants. boot_done=1 -> IDLE.
- IDLE, arbitration:
  - Winner w = the only valid requester; if both are valid, w = prio.
  - req_ready[w]=1 in the same cycle (zero-latency accept). req_ready of the loser stays 0.
  - mem_addr = req_addr[w]; mem_write_data = req_wdata[w]; mem_write_enable = req_we[w].
- IDLE, on handshake:
  - prio <= ~w (the other requester is favoured next time).
  - Write: transaction completes at this edge; no response; stay in IDLE, so back-to-back writes run at 1 per cycle.
  - Read: owner <= w, addr_q <= req_addr[w], go to READ_WAIT.
- IDLE, no valid request: prio unchanged.
- READ_WAIT:
  - mem_addr = addr_q (held stable); no grants.
  - rsp_valid[owner]=1, rsp_rdata=mem_read_data.
  - Next state IDLE unconditionally, so read throughput is 1 per 2 cycles.
  - Read latency, handshake edge to rsp_valid: exactly 1 cycle.
- ERROR:
  - Entered from any state when memory_error=1, or when boot_done=0 in IDLE/READ_WAIT.
  - Error checks take priority over all other transitions.
  - A read pending in READ_WAIT on that cycle gets no rsp_valid.
  - In ERROR: arb_error=1, all grants and mem_write_enable are 0; leave only via rst_n.
- Requesters must hold req_valid, we, addr and wdata stable until the handshake. The arbiter does not check this.
- A request arriving in BOOT or READ_WAIT waits; it is not dropped.
- Reset asserted mid-read: the response is lost; the requester reissues after boot.

Test Plan:
- Reset held, then released with boot_done=0 for 10 cycles while req_valid=2'b11 -> req_ready=0 and mem_write_enable=0 throughout. boot_done=1 -> requester 0 granted the same cycle that IDLE is reached.
- Requester 0 writes 0xDEADBEEF to 0x0010, then reads 0x0010 -> write ready in cycle n; read ready in cycle n+1; rsp_valid=2'b01 in cycle n+2 with rsp_rdata=0xDEADBEEF.
- Both requesters continuously issue writes -> grants alternate 0,1,0,1 on consecutive cycles with no idle cycles.
- Both requesters issue reads -> grant 0, rsp0, grant 1, rsp1 on 4 consecutive cycles. mem_addr is held at addr_q during each READ_WAIT.
- Read accepted, then memory_error=1 in the READ_WAIT cycle -> no rsp_valid, arb_error=1 sticky, req_ready=0 until rst_n pulses low.
- rst_n asserted asynchronously mid-cycle during READ_WAIT -> all outputs go to 0 immediately, without waiting for a clock edge. After reset, prio=0 (requester 0 wins the first conflict).
